down_counter_timer: RTL and testbench

- Loadable down-counter/timer that consumes the same clk/rstb/en/data style interface as the team's up-counter, in the opposite direction.
- Loads a start value, decrements on qualified enable ticks, and signals terminal count with a one-cycle done pulse.
- Sits between control logic (issues load) and a timed consumer (waits on done); also used as a countdown stimulus source for counter benches.

---
 rtl/down_counter_timer_pkg.sv | 13 +
 rtl/en_prescaler.sv | 40 ++++
 rtl/down_counter_timer.sv | 120 ++++++++++++
 tb/tb_down_counter_timer.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/down_counter_timer_pkg.sv
// Shared types and bench defaults for the loadable down-counter/timer.
package down_counter_timer_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEFAULT_WIDTH    = 8;
  localparam int DEFAULT_PRESCALE = 1;

endpackage

// File: rtl/en_prescaler.sv
// Divides qualified enable pulses: one tick per PRESCALE en pulses while clr is low.
module en_prescaler
  import down_counter_timer_pkg::*;
#(
  parameter int PRESCALE = DEFAULT_PRESCALE
) (
  input  logic clk,
  input  logic rstb,
  input  logic clr,
  input  logic en,
  output logic tick
);

  generate
    if (PRESCALE <= 1) begin : g_bypass
      logic unused_ok;
      assign unused_ok = &{1'b0, clk, rstb, clr};
      assign tick      = en;
    end else begin : g_count
      localparam int CW = $clog2(PRESCALE);
      localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

      logic [CW-1:0] cnt_reg;
      logic          at_last;

      assign at_last = (cnt_reg == LAST);
      // Qualify with clr so a load or a non-counting state never produces a tick.
      assign tick    = en & ~clr & at_last;

      always_ff @(posedge clk) begin
        if (!rstb || clr) begin
          cnt_reg <= '0;
        end else if (en) begin
          cnt_reg <= at_last ? '0 : cnt_reg + CW'(1);
        end
      end
    end
  endgenerate

endmodule

// File: rtl/down_counter_timer.sv
// Loadable down-counter/timer with one-cycle done pulse at terminal count.
// Optional periodic reload enabled by defining DOWN_COUNTER_TIMER_AUTO_RELOAD_EN.
module down_counter_timer
  import down_counter_timer_pkg::*;
#(
  parameter int WIDTH    = DEFAULT_WIDTH,
  parameter int PRESCALE = DEFAULT_PRESCALE
) (
  input  logic             clk,
  input  logic             rstb,
  input  logic             load,
  input  logic [WIDTH-1:0] data,
  input  logic             en,
  output logic [WIDTH-1:0] out,
  output logic             busy,
  output logic             done
);

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] out_reg, out_next;
  logic             busy_reg, done_reg;
  logic             tick;
  logic             pre_clr;

`ifdef DOWN_COUNTER_TIMER_AUTO_RELOAD_EN
  logic [WIDTH-1:0] reload_reg, reload_next;
`endif

  // The prescaler only accumulates en pulses while a count is in progress.
  assign pre_clr = (state_reg != RUN) || load;

  en_prescaler #(
    .PRESCALE(PRESCALE)
  ) u_prescaler (
    .clk (clk),
    .rstb(rstb),
    .clr (pre_clr),
    .en  (en),
    .tick(tick)
  );

  always_comb begin
    state_next = state_reg;
    out_next   = out_reg;
`ifdef DOWN_COUNTER_TIMER_AUTO_RELOAD_EN
    reload_next = reload_reg;
    if (load) begin
      reload_next = data;
    end
`endif
    // A load is accepted identically from every state and beats any tick.
    if (load) begin
      out_next   = data;
      state_next = (data != '0) ? RUN : DONE;
    end else begin
      case (state_reg)
        IDLE: begin
          state_next = IDLE;
        end
        RUN: begin
          if (tick) begin
            if (out_reg > WIDTH'(1)) begin
              out_next = out_reg - WIDTH'(1);
            end else begin
              out_next   = '0;
              state_next = DONE;
            end
          end
        end
        DONE: begin
`ifdef DOWN_COUNTER_TIMER_AUTO_RELOAD_EN
          if (reload_reg != '0) begin
            out_next   = reload_reg;
            state_next = RUN;
          end else begin
            out_next   = '0;
            state_next = IDLE;
          end
`else
          out_next   = '0;
          state_next = IDLE;
`endif
        end
        default: begin
          out_next   = '0;
          state_next = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rstb) begin
      state_reg <= IDLE;
      out_reg   <= '0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      out_reg   <= out_next;
      busy_reg  <= (state_next == RUN);
      done_reg  <= (state_next == DONE);
    end
  end

`ifdef DOWN_COUNTER_TIMER_AUTO_RELOAD_EN
  always_ff @(posedge clk) begin
    if (!rstb) begin
      reload_reg <= '0;
    end else begin
      reload_reg <= reload_next;
    end
  end
`endif

  assign out  = out_reg;
  assign busy = busy_reg;
  assign done = done_reg;

endmodule

// File: tb/tb_down_counter_timer.sv
// Bench for down_counter_timer: PRESCALE=1 and PRESCALE=4 instances share stimulus and are
// checked every cycle against a count-of-events reference model.
module tb_down_counter_timer;
  import down_counter_timer_pkg::*;

  localparam int W = DEFAULT_WIDTH;

  logic         clk = 1'b0;
  logic         rstb = 1'b0;
  logic         load = 1'b0;
  logic [W-1:0] data = '0;
  logic         en = 1'b0;
  logic [W-1:0] out1, out4;
  logic         busy1, busy4, done1, done4;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference state per instance: index 0 is PRESCALE=1, index 1 is PRESCALE=4
  int pre[2] = '{1, 4};
  int m_out[2], m_ens[2], m_reload[2];
  bit m_run[2], m_pulse[2];

  always #5 clk = ~clk;

  down_counter_timer #(.WIDTH(W), .PRESCALE(1)) dut1 (
    .clk(clk), .rstb(rstb), .load(load), .data(data), .en(en),
    .out(out1), .busy(busy1), .done(done1)
  );

  down_counter_timer #(.WIDTH(W), .PRESCALE(4)) dut4 (
    .clk(clk), .rstb(rstb), .load(load), .data(data), .en(en),
    .out(out4), .busy(busy4), .done(done4)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_edge();
    for (int i = 0; i < 2; i++) begin
      if (!rstb) begin
        m_out[i] = 0; m_run[i] = 0; m_pulse[i] = 0; m_ens[i] = 0; m_reload[i] = 0;
      end else if (load) begin
        m_out[i]    = int'(data);
        m_run[i]    = (data != 0);
        m_pulse[i]  = (data == 0);
        m_ens[i]    = 0;
        m_reload[i] = int'(data);
      end else if (m_run[i]) begin
        if (en) begin
          m_ens[i]++;
          if (m_ens[i] == pre[i]) begin
            m_ens[i] = 0;
            m_out[i]--;
            if (m_out[i] == 0) begin
              m_run[i]   = 0;
              m_pulse[i] = 1;
            end
          end
        end
      end else if (m_pulse[i]) begin
        m_pulse[i] = 0;
        m_ens[i]   = 0;
`ifdef DOWN_COUNTER_TIMER_AUTO_RELOAD_EN
        if (m_reload[i] != 0) begin
          m_out[i] = m_reload[i];
          m_run[i] = 1;
        end else begin
          m_out[i] = 0;
        end
`else
        m_out[i] = 0;
`endif
      end
    end
  endtask

  // One clock edge: advance the model with the inputs present at the edge, then compare.
  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check("p1_out",  out1,  m_out[0]);
    check("p1_busy", busy1, m_run[0]);
    check("p1_done", done1, m_pulse[0]);
    check("p4_out",  out4,  m_out[1]);
    check("p4_busy", busy4, m_run[1]);
    check("p4_done", done4, m_pulse[1]);
  endtask

  task automatic do_load(input logic [W-1:0] v, input logic en_v);
    load = 1'b1; data = v; en = en_v;
    step();
    load = 1'b0;
  endtask

  // Edges after the load edge until done is seen on the chosen instance; -1 on timeout.
  task automatic count_to_done(input int which, input int en_period, input int limit,
                               output int cycles);
    cycles = -1;
    for (int k = 1; k <= limit; k++) begin
      load = 1'b0;
      en   = (k % en_period == 0);
      step();
      if ((which == 0 && done1) || (which == 1 && done4)) begin
        cycles = k;
        break;
      end
    end
  endtask

  initial begin
    int cyc;
    int r;
    for (int i = 0; i < 2; i++) begin
      m_out[i] = 0; m_run[i] = 0; m_pulse[i] = 0; m_ens[i] = 0; m_reload[i] = 0;
    end

    // Reset held with load asserted
    rstb = 1'b0; load = 1'b1; data = 8'h55; en = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      check("rst_out", out1, 0);
      check("rst_busy", busy1, 0);
    end
    rstb = 1'b1; load = 1'b0; en = 1'b0;
    step();
    check("idle_after_rst", busy1 | done1, 0);

    // Basic countdown, PRESCALE=1
    do_load(8'd5, 1'b1);
    check("load_out", out1, 5);
    count_to_done(0, 1, 50, cyc);
    check("basic_latency", cyc, 5);
    en = 1'b0;
    step();
    check("basic_back_idle", out1, 0);

    // Prescale 4, en every cycle then every 4th cycle
    do_load(8'd3, 1'b0);
    count_to_done(1, 1, 100, cyc);
    check("pre4_latency", cyc, 12);
    do_load(8'd3, 1'b0);
    count_to_done(1, 4, 200, cyc);
    check("pre4_gap_latency", cyc, 48);

    // Restart priority over a simultaneous en
    do_load(8'd10, 1'b1);
    en = 1'b1;
    for (int k = 0; k < 3; k++) step();
    check("restart_pre", out1, 7);
    do_load(8'd2, 1'b1);
    check("restart_out", out1, 2);
    count_to_done(0, 1, 20, cyc);
    check("restart_latency", cyc, 2);

    // Zero-length timer
    do_load(8'd0, 1'b1);
    check("zero_done", done1, 1);
    check("zero_busy", busy1, 0);
    en = 1'b0;
    step();
    check("zero_done_clear", done1, 0);

    // All-ones load: 255 ticks, no wrap
    do_load(8'hFF, 1'b1);
    count_to_done(0, 1, 400, cyc);
    check("ff_latency", cyc, 255);

    // Reset mid-count aborts with no done
    do_load(8'd10, 1'b1);
    en = 1'b1;
    for (int k = 0; k < 3; k++) step();
    check("mid_pre", out1, 7);
    rstb = 1'b0;
    step();
    check("mid_rst_out", out1, 0);
    check("mid_rst_done", done1, 0);
    rstb = 1'b1;
    for (int k = 0; k < 4; k++) step();

`ifdef DOWN_COUNTER_TIMER_AUTO_RELOAD_EN
    // Periodic reload, then a new load during the done cycle changes the period
    do_load(8'd3, 1'b1);
    en = 1'b1;
    cyc = 0;
    for (int k = 0; k < 40 && cyc < 2; k++) begin
      step();
      if (done1) cyc++;
    end
    check("ar_two_pulses", cyc, 2);
    do_load(8'd2, 1'b1);
    check("ar_reload_out", out1, 2);
    check("ar_reload_busy", busy1, 1);
    count_to_done(0, 1, 20, cyc);
    check("ar_first_period", cyc, 2);
    count_to_done(0, 1, 20, cyc);
    check("ar_next_period", cyc, 3);
    do_load(8'd0, 1'b0);
`endif

    // Randomized traffic against the model
    for (int k = 0; k < 3000; k++) begin
      rstb = ($urandom_range(0, 299) != 0);
      load = ($urandom_range(0, 19) == 0);
      r = $urandom_range(0, 9);
      if (r == 0)      data = 8'd0;
      else if (r == 1) data = 8'hFF;
      else if (r < 7)  data = W'($urandom_range(1, 6));
      else             data = W'($urandom);
      en = ($urandom_range(0, 3) != 0);
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
